// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store controller: access sizes, FSM states and
// the access legality helper.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int unsigned WORD_BYTES = 32'd4;
  localparam int unsigned OFF_W      = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } lsu_state_e;

  // Illegal size or an access that crosses its natural alignment.
  function automatic logic access_illegal(input logic [1:0] size, input logic [OFF_W-1:0] off);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: merges store data into a RAM word and extracts and
// extends load data from it.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0]      word,
  input  logic [31:0]      wdata,
  input  logic [OFF_W-1:0] offset,
  input  logic [1:0]       size,
  input  logic             is_unsigned,
  output logic [31:0]      merged,
  output logic [31:0]      load_ext
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select, merge and extension for the active access size.
  always_comb begin
    byte_s   = word[{offset, 3'b000} +: 8];
    half_s   = word[{offset[1], 4'b0000} +: 16];
    merged   = word;
    load_ext = word;
    case (size)
      SZ_B: begin
        merged[{offset, 3'b000} +: 8] = wdata[7:0];
        load_ext = {{24{byte_s[7] & ~is_unsigned}}, byte_s};
      end
      SZ_H: begin
        merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
        load_ext = {{16{half_s[15] & ~is_unsigned}}, half_s};
      end
      SZ_W: begin
        merged   = wdata;
        load_ext = word;
      end
      default: begin
        merged   = word;
        load_ext = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller for a synchronous single-port data RAM with a shared
// tri-state bus. Build option LSU_RANGE_CHECK_EN rejects addresses beyond the RAM.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_clk_i,
  input  logic                  rst_rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [31:0]           req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  mem_cs_o,
  output logic                  mem_we_o,
  output logic                  mem_oe_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  inout  wire  [DATA_WIDTH-1:0] mem_data_io
);

  lsu_state_e            state_r;
  logic                  we_r;
  logic [1:0]            size_r;
  logic                  uns_r;
  logic [OFF_W-1:0]      off_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [DATA_WIDTH-1:0] wr_word_r;
  logic                  ready_r;
  logic                  resp_valid_r;
  logic                  resp_err_r;
  logic [DATA_WIDTH-1:0] resp_rdata_r;
  logic                  cs_r;
  logic                  mem_we_r;
  logic                  oe_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  range_err_s;
  logic                  req_err_s;
  logic [DATA_WIDTH-1:0] merged_s;
  logic [DATA_WIDTH-1:0] load_ext_s;

`ifdef LSU_RANGE_CHECK_EN
  assign range_err_s = |req_addr_i[31:ADDR_WIDTH+2];
`else
  logic unused_upper_addr_s;
  assign unused_upper_addr_s = ^req_addr_i[31:ADDR_WIDTH+2];
  assign range_err_s = 1'b0;
`endif

  assign req_err_s = access_illegal(req_size_i, req_addr_i[OFF_W-1:0]) | range_err_s;

  lsu_lane_align u_lane_align (
    .word        (mem_data_io),
    .wdata       (wdata_r),
    .offset      (off_r),
    .size        (size_r),
    .is_unsigned (uns_r),
    .merged      (merged_s),
    .load_ext    (load_ext_s)
  );

  // Transaction FSM; every output is registered from the state being entered.
  always_ff @(posedge clk_clk_i or posedge rst_rst_i) begin
    if (rst_rst_i) begin
      state_r      <= ST_IDLE;
      we_r         <= 1'b0;
      size_r       <= SZ_B;
      uns_r        <= 1'b0;
      off_r        <= '0;
      wdata_r      <= '0;
      wr_word_r    <= '0;
      ready_r      <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= '0;
      cs_r         <= 1'b0;
      mem_we_r     <= 1'b0;
      oe_r         <= 1'b0;
      addr_r       <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid_i) begin
            we_r         <= req_we_i;
            size_r       <= req_size_i;
            uns_r        <= req_unsigned_i;
            off_r        <= req_addr_i[OFF_W-1:0];
            wdata_r      <= req_wdata_i;
            wr_word_r    <= req_wdata_i;
            resp_rdata_r <= '0;
            ready_r      <= 1'b0;
            if (req_err_s) begin
              state_r      <= ST_RESP;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
            end else if (req_we_i && (req_size_i == SZ_W)) begin
              state_r  <= ST_WR;
              addr_r   <= req_addr_i[ADDR_WIDTH+1:2];
              cs_r     <= 1'b1;
              mem_we_r <= 1'b1;
            end else begin
              state_r <= ST_RD;
              addr_r  <= req_addr_i[ADDR_WIDTH+1:2];
              cs_r    <= 1'b1;
              oe_r    <= 1'b1;
            end
          end
        end
        ST_RD: begin
          state_r <= ST_CAP;
        end
        ST_CAP: begin
          oe_r <= 1'b0;
          if (we_r) begin
            state_r   <= ST_WR;
            wr_word_r <= merged_s;
            mem_we_r  <= 1'b1;
          end else begin
            state_r      <= ST_RESP;
            resp_rdata_r <= load_ext_s;
            resp_valid_r <= 1'b1;
            cs_r         <= 1'b0;
          end
        end
        ST_WR: begin
          state_r      <= ST_RESP;
          cs_r         <= 1'b0;
          mem_we_r     <= 1'b0;
          resp_valid_r <= 1'b1;
        end
        ST_RESP: begin
          state_r      <= ST_IDLE;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= '0;
          ready_r      <= 1'b1;
        end
        default: begin
          state_r      <= ST_IDLE;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= '0;
          cs_r         <= 1'b0;
          mem_we_r     <= 1'b0;
          oe_r         <= 1'b0;
          ready_r      <= 1'b1;
        end
      endcase
    end
  end

  // The bus is driven only while writing, so it can never fight the RAM's output.
  assign mem_data_io  = mem_we_r ? wr_word_r : {DATA_WIDTH{1'bz}};

  assign req_ready_o  = ready_r;
  assign resp_valid_o = resp_valid_r;
  assign resp_err_o   = resp_err_r;
  assign resp_rdata_o = resp_rdata_r;
  assign mem_cs_o     = cs_r;
  assign mem_we_o     = mem_we_r;
  assign mem_oe_o     = oe_r;
  assign mem_addr_o   = addr_r;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized self-checking bench for lsu_mem_ctrl with a behavioural RAM and a
// byte-level reference memory.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_cs;
  logic        mem_we;
  logic        mem_oe;
  logic [7:0]  mem_addr;
  wire  [31:0] mem_data;

  int errors = 0;
  int checks = 0;

  logic [31:0] ram [0:255];
  logic [31:0] ram_q;
  logic [31:0] ref_mem [0:255];

  logic        any_strobe;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  int          last_lat;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk_clk_i      (clk),
    .rst_rst_i      (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .resp_valid_o   (resp_valid),
    .resp_rdata_o   (resp_rdata),
    .resp_err_o     (resp_err),
    .mem_cs_o       (mem_cs),
    .mem_we_o       (mem_we),
    .mem_oe_o       (mem_oe),
    .mem_addr_o     (mem_addr),
    .mem_data_io    (mem_data)
  );

  // Synchronous single-port RAM: registered read, drives the bus while selected for read.
  assign mem_data = (mem_cs && mem_oe && !mem_we) ? ram_q : 32'hzzzz_zzzz;
  always @(posedge clk) begin
    if (mem_cs && mem_we) ram[mem_addr] <= mem_data;
    else if (mem_cs && mem_oe) ram_q <= ram[mem_addr];
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input int nb, input logic [1:0] off);
    logic [31:0] m;
    m = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    return m << (8 * off);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] off,
                                             input int nb, input logic uns);
    logic [31:0] v;
    logic [31:0] m;
    v = word >> (8 * off);
    if (nb == 4) return v;
    m = (32'd1 << (8 * nb)) - 32'd1;
    v = v & m;
    if (!uns && v[8*nb-1]) v = v | ~m;
    return v;
  endfunction

  // One request end to end, checked against the reference memory.
  task automatic run(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd, output logic [31:0] rd);
    logic [7:0]  w;
    logic [1:0]  off;
    logic        exp_err;
    int          nb;
    int          exp_lat;
    logic [31:0] exp_rd;
    logic        done;
    logic        got_err;
    int          g;
    int          clash;

    w   = addr[9:2];
    off = addr[1:0];
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    exp_err = (sz == 2'd3) || (sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'd0);
`ifdef LSU_RANGE_CHECK_EN
    if (addr[31:10] != 22'd0) exp_err = 1'b1;
`endif
    exp_lat = exp_err ? 1 : (!we ? 3 : (sz == 2'd2 ? 2 : 4));
    exp_rd  = (exp_err || we) ? 32'd0 : model_load(ref_mem[w], off, nb, uns);
    if (!exp_err && we)
      ref_mem[w] = (ref_mem[w] & ~lane_mask(nb, off)) | ((wd << (8 * off)) & lane_mask(nb, off));

    @(negedge clk);
    g = 0;
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    check_val("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;

    done = 1'b0; any_strobe = 1'b0; clash = 0; last_lat = 0;
    rd = 32'd0; got_err = 1'b0;
    for (int n = 1; n <= 20 && !done; n++) begin
      @(negedge clk);
      if (mem_oe && mem_we) clash++;
      if (mem_cs || mem_we || mem_oe) any_strobe = 1'b1;
      if (mem_we) begin
        wr_addr = mem_addr;
        wr_data = mem_data;
      end
      if (resp_valid) begin
        done = 1'b1;
        last_lat = n;
        rd = resp_rdata;
        got_err = resp_err;
      end
    end
    check_val("resp_seen", {31'd0, done}, 32'd1);
    check_val("latency", last_lat, exp_lat);
    check_val("resp_err", {31'd0, got_err}, {31'd0, exp_err});
    check_val("resp_rdata", rd, exp_rd);
    check_val("no_contention", clash, 32'd0);
    if (exp_err) check_val("err_no_strobes", {31'd0, any_strobe}, 32'd0);
    check_val("ram_word", ram[w], ref_mem[w]);
  endtask

  initial begin
    logic [31:0] rd;
    int          g;
    logic        saw_resp;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    #12;
    check_val("rst_ready", {31'd0, req_ready}, 32'd1);
    check_val("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_val("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check_val("rst_rdata", resp_rdata, 32'd0);
    check_val("rst_strobes", {29'd0, mem_cs, mem_we, mem_oe}, 32'd0);
    check_val("rst_addr", {24'd0, mem_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run(1'b1, 2'd2, 1'b0, i * 4, $urandom, rd);

    // Directed cases from the test plan.
    run(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd);
    check_val("tp_wr_addr", {24'd0, wr_addr}, 32'd4);
    check_val("tp_wr_bus", wr_data, 32'hDEADBEEF);
    run(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd);
    check_val("tp_word_load", rd, 32'hDEADBEEF);
    check_val("tp_word_load_lat", last_lat, 32'd3);
    run(1'b1, 2'd0, 1'b0, 32'h12, 32'h55, rd);
    check_val("tp_byte_store_ram", ram[4], 32'hDE55BEEF);
    check_val("tp_byte_store_lat", last_lat, 32'd4);
    run(1'b0, 2'd0, 1'b0, 32'h13, 32'd0, rd);
    check_val("tp_byte_signed", rd, 32'hFFFFFFDE);
    run(1'b0, 2'd0, 1'b1, 32'h13, 32'd0, rd);
    check_val("tp_byte_unsigned", rd, 32'h000000DE);
    run(1'b0, 2'd1, 1'b0, 32'h10, 32'd0, rd);
    check_val("tp_half_signed", rd, 32'hFFFFBEEF);
    run(1'b0, 2'd1, 1'b0, 32'h11, 32'd0, rd);
    check_val("tp_half_misaligned_lat", last_lat, 32'd1);
    run(1'b1, 2'd3, 1'b0, 32'h10, 32'h12345678, rd);
    check_val("tp_size11_ram", ram[4], 32'hDE55BEEF);
    run(1'b0, 2'd2, 1'b0, 32'h400, 32'd0, rd);

    // Reset asserted while a load is in its capture cycle.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h10;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("midrst_strobes", {29'd0, mem_cs, mem_we, mem_oe}, 32'd0);
    check_val("midrst_ready", {31'd0, req_ready}, 32'd1);
    check_val("midrst_resp", {31'd0, resp_valid}, 32'd0);
    check_val("midrst_addr", {24'd0, mem_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_resp = 1'b0;
    for (g = 0; g < 4; g++) begin
      @(negedge clk);
      if (resp_valid) saw_resp = 1'b1;
    end
    check_val("midrst_no_resp", {31'd0, saw_resp}, 32'd0);
    run(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd);
    check_val("after_rst_load", rd, 32'hDE55BEEF);

    // Randomized traffic over eight words, occasionally with upper address bits set.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FC00) : 32'd0;
      a = a | $urandom_range(0, 31);
      run($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
          a, $urandom, rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
